systolic_skew_feeder: RTL and testbench
=======================================

SYSTOLIC_SKEW_FEEDER -- requirements
Module: systolic_skew_feeder

Interface
REQ-001 The block SHALL have parameter BIT_WIDTH, default 16, meaning the element width in Q(BIT_WIDTH-FRAC) two's complement (opaque to this block).
REQ-002 The block SHALL have parameter N, default 4, meaning the number of lanes (array rows or columns fed); legal N >= 1.
REQ-003 The block SHALL have port clk, input, 1 bit: clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: upstream vector valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: block accepts a vector this cycle.
REQ-007 The block SHALL have port in_data, input, N*BIT_WIDTH bits: lane i at bits [i*BIT_WIDTH +: BIT_WIDTH].
REQ-008 The block SHALL have port in_last, input, 1 bit: the accepted vector is the final one of the block.
REQ-009 The block SHALL have port out_data, output, N*BIT_WIDTH bits: skewed lanes to the PE edge, same lane packing.
REQ-010 The block SHALL have port pe_clr_n, output, 1 bit: active-low accumulator clear for the PE array.
REQ-011 The block SHALL have port block_done, output, 1 bit: one-cycle pulse when the block is fully skewed out.
REQ-012 The block SHALL have port bubble_cnt, output, 16 bits: count of injected bubble cycles (see Configuration).

Function
REQ-013 A vector SHALL be accepted on a rising edge where in_valid && in_ready.
REQ-014 States SHALL be IDLE, STREAM, FLUSH, DONE; in_ready SHALL be 1 in IDLE and STREAM and 0 in FLUSH and DONE.
REQ-015 Lane i of an accepted vector SHALL appear on out_data lane i exactly i+1 cycles after the accepting edge (lane 0 registered once; lane i has i+1 stages).
REQ-016 On every cycle in which no vector is accepted, zero SHALL enter stage 0 of every lane; the skew stages SHALL shift every cycle, with no stall.
REQ-017 IDLE & accept & !in_last SHALL go to STREAM; IDLE or STREAM & accept & in_last SHALL go to FLUSH, or to DONE when N==1.
REQ-018 STREAM without an accepted vector SHALL remain in STREAM, injecting zeros per REQ-016.
REQ-019 FLUSH SHALL last exactly N-1 cycles, timed by a flush counter, then go to DONE; block_done SHALL be 1 only in DONE, and DONE SHALL go to IDLE after one cycle.
REQ-020 pe_clr_n SHALL be combinational, 0 exactly when state==IDLE && in_valid, else 1, so PE accumulators clear on the same edge that loads the first vector.
REQ-021 PE results SHALL NOT be disturbed outside REQ-020, so results hold after block_done until the next block starts.
REQ-022 in_data and in_last SHALL be ignored when no vector is accepted.
REQ-023 A single-vector block (in_last on the first accept) SHALL follow REQ-017 directly from IDLE.

Reset
REQ-024 While rst_n==0 at a rising edge: state SHALL go to IDLE, all skew stages and out_data to 0, flush counter to 0, block_done to 0, bubble_cnt to 0.
REQ-025 Reset asserted mid-block SHALL discard in-flight data with no block_done pulse; in_ready SHALL be 1 in the first cycle after release.

Configuration
REQ-026 Macro FEEDER_BUBBLE_CNT_EN SHALL control the bubble counter; when defined, bubble_cnt SHALL increment, saturating at 16'hFFFF, on every STREAM cycle without an accepted vector, and clear on reset and on the first accept of each block.
REQ-027 When FEEDER_BUBBLE_CNT_EN is not defined, bubble_cnt SHALL be constant 0, no counter logic SHALL exist, and all other behaviour SHALL be identical.

Verification
REQ-028 With N=4, accept vectors {1,2,3,4}, {5,6,7,8} (last) back-to-back -> lane0 shows 1,5 at cycles +1,+2; lane3 shows 4,8 at +4,+5; block_done at +5; zeros elsewhere.
REQ-029 With N=4, a single vector {7,7,7,7} with in_last from IDLE -> pe_clr_n low in the accept cycle only; FLUSH 3 cycles; block_done 1 cycle; in_ready low 4 cycles.
REQ-030 With in_valid gaps (accept, 2 idle cycles, accept last) and FEEDER_BUBBLE_CNT_EN defined -> zeros between elements on every lane; bubble_cnt==2; undefined -> bubble_cnt==0.
REQ-031 rst_n low for one cycle during FLUSH -> all out_data 0, no block_done, state IDLE, in_ready 1.
REQ-032 With N=1, accept {9} with in_last -> out lane0=9 at +1, DONE next cycle, no FLUSH cycles.
REQ-033 in_valid held high with in_last during DONE -> not accepted; accepted in the following IDLE cycle with pe_clr_n low.

Source files
------------

// File: rtl/systolic_skew_feeder.sv
// Skews an N-lane vector stream so lane i reaches the PE edge i+1 cycles after acceptance, then flushes and pulses block_done.
// Optional bubble counter is built only when FEEDER_BUBBLE_CNT_EN is defined.
module systolic_skew_feeder #(
  parameter int BIT_WIDTH = 16,
  parameter int N         = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N*BIT_WIDTH-1:0] in_data,
  input  logic                   in_last,
  output logic [N*BIT_WIDTH-1:0] out_data,
  output logic                   pe_clr_n,
  output logic                   block_done,
  output logic [15:0]            bubble_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FLUSH, S_DONE} state_t;

  localparam int FLUSH_LAST = (N > 1) ? N - 2 : 0;
  localparam int CW         = (N > 2) ? $clog2(N - 1) : 1;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   flush_cnt;
  logic            accept;

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // A single-lane array has nothing left to drain, so the last vector goes straight to DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_STREAM: begin
        if (accept) begin
          if (in_last) state_nxt = (N == 1) ? S_DONE : S_FLUSH;
          else         state_nxt = S_STREAM;
        end
      end
      S_FLUSH: begin
        if (flush_cnt == CW'(FLUSH_LAST)) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready   = (state == S_IDLE) || (state == S_STREAM);
    block_done = (state == S_DONE);
    pe_clr_n   = !((state == S_IDLE) && in_valid);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                flush_cnt <= '0;
    else if (state == S_FLUSH) flush_cnt <= flush_cnt + 1'b1;
    else                       flush_cnt <= '0;
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    logic [BIT_WIDTH-1:0] pipe [gi+1];

    // Stages shift unconditionally; zeros fill in whenever nothing is accepted.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int j = 0; j <= gi; j++) pipe[j] <= '0;
      end else begin
        pipe[0] <= accept ? in_data[gi*BIT_WIDTH +: BIT_WIDTH] : '0;
        for (int j = 1; j <= gi; j++) pipe[j] <= pipe[j-1];
      end
    end

    assign out_data[gi*BIT_WIDTH +: BIT_WIDTH] = pipe[gi];
  end

`ifdef FEEDER_BUBBLE_CNT_EN
  logic [15:0] bubble_q;

  always_ff @(posedge clk) begin
    if (!rst_n)
      bubble_q <= '0;
    else if ((state == S_IDLE) && accept)
      bubble_q <= '0;
    else if ((state == S_STREAM) && !accept && (bubble_q != 16'hFFFF))
      bubble_q <= bubble_q + 16'd1;
  end

  assign bubble_cnt = bubble_q;
`else
  assign bubble_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder: N=4 instance for skew/flush/reset cases, N=1 instance for the degenerate block.
module tb_systolic_skew_feeder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        in_last;
  logic [63:0] out_data;
  logic        pe_clr_n;
  logic        block_done;
  logic [15:0] bubble_cnt;

  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic        s_last;
  logic [15:0] s_out;
  logic        s_clr_n;
  logic        s_done;
  logic [15:0] s_bubble;

  int checks   = 0;
  int failures = 0;

  systolic_skew_feeder #(.BIT_WIDTH(16), .N(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_data   (out_data),
    .pe_clr_n   (pe_clr_n),
    .block_done (block_done),
    .bubble_cnt (bubble_cnt)
  );

  systolic_skew_feeder #(.BIT_WIDTH(16), .N(1)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (s_valid),
    .in_ready   (s_ready),
    .in_data    (s_data),
    .in_last    (s_last),
    .out_data   (s_out),
    .pe_clr_n   (s_clr_n),
    .block_done (s_done),
    .bubble_cnt (s_bubble)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pk(input logic [15:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of stimulus, check the cycle's outputs, advance past the next edge.
  task automatic cyc(input string tag, input logic v, input logic l, input logic [63:0] d,
                     input logic [63:0] eo, input logic er, input logic ed, input logic ec);
    in_valid = v;
    in_last  = l;
    in_data  = d;
    #1;
    check({tag, "_out"},  out_data,   eo);
    check({tag, "_rdy"},  in_ready,   er);
    check({tag, "_done"}, block_done, ed);
    check({tag, "_clr"},  pe_clr_n,   ec);
    tick();
  endtask

  localparam logic [63:0] JUNK = 64'hDEAD_BEEF_CAFE_F00D;
  logic [15:0] exp_bubble;

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    s_valid  = 1'b0;
    s_last   = 1'b0;
    s_data   = '0;
    tick();
    tick();
    check("rst_out",    out_data,   64'h0);
    check("rst_rdy",    in_ready,   1'b1);
    check("rst_done",   block_done, 1'b0);
    check("rst_bubble", bubble_cnt, 16'h0);
    check("rst_clr",    pe_clr_n,   1'b1);
    rst_n = 1'b1;
    tick();

    // Two back-to-back vectors, second is last.
    cyc("bb0", 1, 0, pk(1, 2, 3, 4), 64'h0,        1, 0, 0);
    cyc("bb1", 1, 1, pk(5, 6, 7, 8), pk(1, 0, 0, 0), 1, 0, 1);
    cyc("bb2", 0, 0, JUNK,           pk(5, 2, 0, 0), 0, 0, 1);
    cyc("bb3", 0, 0, JUNK,           pk(0, 6, 3, 0), 0, 0, 1);
    cyc("bb4", 0, 0, JUNK,           pk(0, 0, 7, 4), 0, 0, 1);
    cyc("bb5", 0, 0, JUNK,           pk(0, 0, 0, 8), 0, 1, 1);
    cyc("bb6", 0, 0, JUNK,           64'h0,        1, 0, 1);

    // Single vector, then in_valid held through FLUSH/DONE; next vector taken only in IDLE.
    cyc("sv0", 1, 1, pk(7, 7, 7, 7), 64'h0,        1, 0, 0);
    cyc("sv1", 1, 1, pk(9, 9, 9, 9), pk(7, 0, 0, 0), 0, 0, 1);
    cyc("sv2", 1, 1, pk(9, 9, 9, 9), pk(0, 7, 0, 0), 0, 0, 1);
    cyc("sv3", 1, 1, pk(9, 9, 9, 9), pk(0, 0, 7, 0), 0, 0, 1);
    cyc("sv4", 1, 1, pk(9, 9, 9, 9), pk(0, 0, 0, 7), 0, 1, 1);
    cyc("sv5", 1, 1, pk(9, 9, 9, 9), 64'h0,        1, 0, 0);
    cyc("sv6", 0, 0, JUNK,           pk(9, 0, 0, 0), 0, 0, 1);
    cyc("sv7", 0, 0, JUNK,           pk(0, 9, 0, 0), 0, 0, 1);
    cyc("sv8", 0, 0, JUNK,           pk(0, 0, 9, 0), 0, 0, 1);
    cyc("sv9", 0, 0, JUNK,           pk(0, 0, 0, 9), 0, 1, 1);
    cyc("svA", 0, 0, JUNK,           64'h0,        1, 0, 1);

    // Gapped block: junk on the bus while idle in STREAM must not leak through.
    cyc("gp0", 1, 0, pk(16'h11, 16'h12, 16'h13, 16'h14), 64'h0,                 1, 0, 0);
    cyc("gp1", 0, 1, JUNK,                               pk(16'h11, 0, 0, 0),   1, 0, 1);
    cyc("gp2", 0, 0, JUNK,                               pk(0, 16'h12, 0, 0),   1, 0, 1);
    cyc("gp3", 1, 1, pk(16'h21, 16'h22, 16'h23, 16'h24), pk(0, 0, 16'h13, 0),   1, 0, 1);
    cyc("gp4", 0, 0, JUNK,                               pk(16'h21, 0, 0, 16'h14), 0, 0, 1);
    cyc("gp5", 0, 0, JUNK,                               pk(0, 16'h22, 0, 0),   0, 0, 1);
    cyc("gp6", 0, 0, JUNK,                               pk(0, 0, 16'h23, 0),   0, 0, 1);
    cyc("gp7", 0, 0, JUNK,                               pk(0, 0, 0, 16'h24),   0, 1, 1);
    cyc("gp8", 0, 0, JUNK,                               64'h0,                 1, 0, 1);
`ifdef FEEDER_BUBBLE_CNT_EN
    exp_bubble = 16'd2;
`else
    exp_bubble = 16'd0;
`endif
    check("gap_bubble", bubble_cnt, exp_bubble);

    // Reset pulse during FLUSH discards the block.
    cyc("rf0", 1, 1, pk(5, 5, 5, 5), 64'h0, 1, 0, 0);
    rst_n = 1'b0;
    cyc("rf1", 0, 0, JUNK, pk(5, 0, 0, 0), 0, 0, 1);
    rst_n = 1'b1;
    cyc("rf2", 0, 0, JUNK, 64'h0, 1, 0, 1);
    cyc("rf3", 0, 0, JUNK, 64'h0, 1, 0, 1);
    cyc("rf4", 0, 0, JUNK, 64'h0, 1, 0, 1);
    cyc("rf5", 0, 0, JUNK, 64'h0, 1, 0, 1);
    check("rf_bubble", bubble_cnt, 16'h0);

    // N=1 instance: no FLUSH, DONE right after the accept cycle.
    s_valid = 1'b1;
    s_last  = 1'b1;
    s_data  = 16'd9;
    #1;
    check("n1_c0_rdy", s_ready, 1'b1);
    check("n1_c0_clr", s_clr_n, 1'b0);
    check("n1_c0_out", s_out,   16'h0);
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = 16'hBEEF;
    #1;
    check("n1_c1_out",  s_out,   16'd9);
    check("n1_c1_done", s_done,  1'b1);
    check("n1_c1_rdy",  s_ready, 1'b0);
    tick();
    check("n1_c2_out",  s_out,   16'h0);
    check("n1_c2_done", s_done,  1'b0);
    check("n1_c2_rdy",  s_ready, 1'b1);
    check("n1_bubble",  s_bubble, 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
